// File: rtl/ym3438_dbg_pkg.sv
// ym3438_dbg_pkg: shared state encoding and sizing constants for the debug read chain capture.
package ym3438_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } dbg_state_t;

    localparam int DBG_PG_WIDTH    = 10;
    localparam int DBG_ARM_TIMEOUT = 48;

endpackage

// File: rtl/ym3438_dbg_deser.sv
// ym3438_dbg_deser: LSB-first deserialiser with bit index, sample enable, clear and last-bit flag.
module ym3438_dbg_deser
    import ym3438_dbg_pkg::*;
#(
    parameter int DATA_WIDTH = DBG_PG_WIDTH
) (
    input  logic                  MCLK,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  din,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  done
);

    localparam int IDX_W = $clog2(DATA_WIDTH);

    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] sr;

    assign done = en && (idx == IDX_W'(DATA_WIDTH - 1));
    // The final bit is merged in combinationally so the word is complete on the last tick.
    assign word = {din, sr[DATA_WIDTH-2:0]};

    always_ff @(posedge MCLK) begin
        if (reset || clr) begin
            idx <= '0;
            sr  <= '0;
        end else if (en) begin
            sr[idx] <= din;
            idx     <= done ? idx : idx + 1'b1;
        end
    end

endmodule

// File: rtl/ym3438_dbg_capture.sv
// ym3438_dbg_capture: arms on request, captures one serial debug word and hands it off via valid/ack.
module ym3438_dbg_capture
    import ym3438_dbg_pkg::*;
#(
    parameter int DATA_WIDTH  = DBG_PG_WIDTH,
    parameter int ARM_TIMEOUT = DBG_ARM_TIMEOUT,
    parameter int CNT_W       = 6
) (
    input  logic                  MCLK,
    input  logic                  reset,
    input  logic                  c1,
    input  logic                  c2,
    input  logic                  arm,
    input  logic                  load,
    input  logic                  dbg_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ack,
    output logic                  busy,
    output logic                  overrun,
    output logic                  timeout
);

    dbg_state_t            state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic                  load_edge, expire, shift_clr, shift_en, shift_done;
    logic [DATA_WIDTH-1:0] word;

    // A c1 edge overlapping c2 is malformed; the load check is skipped there.
    assign load_edge = c1 && !c2 && load;
    assign expire    = c2 && (cnt == CNT_W'(ARM_TIMEOUT - 1));
    assign shift_clr = (state == ARMED) && load_edge;
    assign shift_en  = (state == SHIFT) && c2;

    ym3438_dbg_deser #(.DATA_WIDTH(DATA_WIDTH)) u_deser (
        .MCLK  (MCLK),
        .reset (reset),
        .clr   (shift_clr),
        .en    (shift_en),
        .din   (dbg_in),
        .word  (word),
        .done  (shift_done)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = arm ? ARMED : IDLE;
            ARMED:   state_nxt = load_edge ? SHIFT : expire ? IDLE : ARMED;
            SHIFT:   state_nxt = shift_done ? DONE : SHIFT;
            DONE:    state_nxt = data_ack ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state   <= state_nxt;
            busy    <= (state_nxt == ARMED) || (state_nxt == SHIFT);
            timeout <= (state == ARMED) && !load_edge && expire;
            if (state == IDLE && arm) begin
                overrun <= 1'b0;
                cnt     <= '0;
            end else if (state == ARMED && c2) begin
                cnt <= cnt + 1'b1;
            end
            if (state == DONE && load_edge)
                overrun <= 1'b1;
            if (shift_done) begin
                data_out   <= word;
                data_valid <= 1'b1;
            end else if (state == DONE && data_ack) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ym3438_dbg_capture.sv
// tb_ym3438_dbg_capture: directed scenarios with hand-computed expectations for the debug capture block.
module tb_ym3438_dbg_capture;

    logic       MCLK = 1'b0;
    logic       reset = 1'b0, c1 = 1'b0, c2 = 1'b0, arm = 1'b0, load = 1'b0;
    logic       dbg_in = 1'b0, data_ack = 1'b0;
    logic [9:0] data_out;
    logic       data_valid, busy, overrun, timeout;
    int         checks = 0;
    int         errors = 0;

    ym3438_dbg_capture dut (
        .MCLK       (MCLK),
        .reset      (reset),
        .c1         (c1),
        .c2         (c2),
        .arm        (arm),
        .load       (load),
        .dbg_in     (dbg_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .busy       (busy),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    always #5 MCLK = ~MCLK;

    task automatic step(input logic a_c1, a_c2, a_ld, a_d, a_arm, a_ack, a_rst);
        c1 = a_c1; c2 = a_c2; load = a_ld; dbg_in = a_d;
        arm = a_arm; data_ack = a_ack; reset = a_rst;
        @(posedge MCLK);
        #1;
        c1 = 0; c2 = 0; load = 0; arm = 0; data_ack = 0; reset = 0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // One internal cycle: c1 pulse, gap, c2 pulse, gap.
    task automatic icycle(input logic ld, input logic d);
        step(1, 0, ld, 0, 0, 0, 0);
        idle();
        step(0, 1, 0, d, 0, 0, 0);
        idle();
    endtask

    task automatic feed(input logic [9:0] w, input int from, input int to, input int ld_at);
        for (int k = from; k < to; k++) icycle(k == ld_at, w[k]);
    endtask

    task automatic last_bit(input logic [9:0] w, input string tag);
        step(1, 0, 0, 0, 0, 0, 0);
        idle();
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s early_valid: got %b expected 0", tag, data_valid);
        end
        step(0, 1, 0, w[9], 0, 0, 0);
        checks++;
        if (data_valid !== 1'b1 || data_out !== w) begin
            errors++;
            $display("FAIL %s word: got valid=%b data=%h expected valid=1 data=%h", tag, data_valid, data_out, w);
        end
        idle();
    endtask

    task automatic capture(input logic [9:0] w, input string tag);
        feed(w, 0, 9, 0);
        last_bit(w, tag);
    endtask

    task automatic test_reset();
        step(1, 0, 1, 1, 1, 1, 1);
        checks++;
        if ({data_out, data_valid, busy, overrun, timeout} !== 14'd0) begin
            errors++;
            $display("FAIL reset: got data=%h valid=%b busy=%b ovr=%b to=%b expected all 0",
                     data_out, data_valid, busy, overrun, timeout);
        end
    endtask

    task automatic test_capture();
        step(0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL arm_busy: got %b expected 1", busy); end
        capture(10'h2A5, "cap_2a5");
        for (int i = 0; i < 5; i++) begin
            idle();
            checks++;
            if (data_valid !== 1'b1 || data_out !== 10'h2A5 || busy !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: got valid=%b data=%h busy=%b expected 1/2a5/0", i, data_valid, data_out, busy);
            end
        end
        step(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (data_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ack: got valid=%b busy=%b expected 0/0", data_valid, busy);
        end
    endtask

    task automatic test_timeout();
        step(0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0);
        for (int t = 0; t < 47; t++) icycle(0, 0);
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_timeout: got to=%b busy=%b expected 0/1", timeout, busy);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        idle();
        step(0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (timeout !== 1'b1 || busy !== 1'b0 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout: got to=%b busy=%b valid=%b expected 1/0/0", timeout, busy, data_valid);
        end
        idle();
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got %b expected 0", timeout); end
        for (int k = 0; k < 11; k++) icycle(k == 0, 1'b1);
        checks++;
        if (data_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_timeout_load: got valid=%b busy=%b expected 0/0", data_valid, busy);
        end
    endtask

    task automatic test_overrun();
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0);
        capture(10'h3FF, "cap_3ff");
        icycle(1, 0);
        checks++;
        if (overrun !== 1'b1 || data_out !== 10'h3FF || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got ovr=%b data=%h valid=%b expected 1/3ff/1", overrun, data_out, data_valid);
        end
        step(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (overrun !== 1'b1 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_sticky: got ovr=%b valid=%b expected 1/0", overrun, data_valid);
        end
        step(0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (overrun !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL overrun_clear: got ovr=%b busy=%b expected 0/1", overrun, busy);
        end
    endtask

    task automatic test_mid_shift();
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0);
        feed(10'h155, 0, 4, 0);
        feed(10'h155, 4, 9, 4);
        last_bit(10'h155, "midload");
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        feed(10'h155, 0, 4, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (data_out !== 10'h000 || data_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got data=%h valid=%b busy=%b expected 000/0/0", data_out, data_valid, busy);
        end
    endtask

    task automatic test_arm_ack();
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0);
        capture(10'h0C3, "cap_0c3");
        step(0, 0, 0, 0, 1, 1, 0);
        checks++;
        if (data_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arm_ack: got valid=%b busy=%b expected 0/0", data_valid, busy);
        end
        for (int k = 0; k < 11; k++) icycle(k == 0, 1'b1);
        checks++;
        if (data_valid !== 1'b0 || busy !== 1'b0 || data_out !== 10'h0C3) begin
            errors++;
            $display("FAIL no_rearm: got valid=%b busy=%b data=%h expected 0/0/0c3", data_valid, busy, data_out);
        end
        step(0, 0, 0, 0, 1, 0, 0);
        capture(10'h16A, "rearm_16a");
    endtask

    task automatic test_c2_load();
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0, 0);
        idle();
        checks++;
        if (busy !== 1'b1 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL c2_load: got busy=%b valid=%b expected 1/0", busy, data_valid);
        end
        capture(10'h1B6, "cap_1b6");
    endtask

    initial begin
        test_reset();
        test_capture();
        test_timeout();
        test_overrun();
        test_mid_shift();
        test_arm_ack();
        test_c2_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
